literal_pack_fifo: RTL

- Parametrised byte-in / word-out literal buffer for the LZ4 compressor datapath.
- Sits between the match search, which emits unmatched literal bytes, and the sequence/token packer, which consumes whole words.
- Packs bytes into WORD_BYTES-wide words. A run flush (byte_done) closes a partial word, and each stored word carries its valid-byte count.
- Read side is first-word-fall-through with a real valid/ready handshake, exact counters and sticky error flags.

---
 rtl/lz4_pkg.sv | 30 +++
 rtl/literal_pack_ram.sv | 33 +++
 rtl/literal_pack_fifo.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/lz4_pkg.sv
// lz4_pkg: shared definitions for the LZ4 literal path.
//   - WORD_BYTES_DEF : default bytes per packed literal word
//   - commit_e       : commit/flush encoding shared with the token packer
//   - calc_aw        : word address width for a given RAM depth
//   - calc_bcw       : width of a byte-count field able to hold 0..wb
//   - lane_lsb       : bit offset of byte lane 'lane' (lane 0 is the MSB lane)
package lz4_pkg;

    localparam int unsigned WORD_BYTES_DEF = 4;

    typedef enum logic [1:0] {
        CommitNone  = 2'd0,  // nothing written this cycle
        CommitFull  = 2'd1,  // complete word written
        CommitFlush = 2'd2,  // partial word closed by byte_done
        CommitDefer = 2'd3   // flush needed but FIFO full; held in flush_pend
    } commit_e;

    function automatic int unsigned calc_aw(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned calc_bcw(input int unsigned wb);
        return $clog2(wb + 1);
    endfunction

    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned wb);
        return 8 * (wb - 1 - lane);
    endfunction

endpackage

// File: rtl/literal_pack_ram.sv
// literal_pack_ram: inferred simple dual-port RAM, one write port, one
// synchronous read port, no reset. rdata holds its value while re is low,
// which the FIFO relies on to park one prefetched word.
//   clk   : clock
//   we    : write enable, waddr/wdata : write port
//   re    : read enable,  raddr       : read address
//   rdata : registered read data
module literal_pack_ram #(
    parameter int unsigned WIDTH = 35,
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = 12
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/literal_pack_fifo.sv
// literal_pack_fifo: byte-in / word-out literal buffer.
// Bytes are packed MSB lane first into WORD_BYTES-wide words; byte_done closes
// a partial word. Each stored word carries its valid-byte count. The read side
// is first-word-fall-through: RAM sync read feeds a one-entry output stage,
// with the RAM read register acting as a one-word prefetch buffer so
// back-to-back pops sustain one word per clock.
//   clk, rstN        : clock, synchronous active-low reset
//   din, wr_en       : literal byte input (dropped while full)
//   byte_done        : end of literal run, flush partial word
//   dout, dout_bytes : head word and its byte count (zero when !valid)
//   valid, rd_en     : head present / pop
//   full, empty      : committed-word occupancy flags
//   word_count       : committed words (RAM + prefetch + output stage)
//   byte_count       : committed bytes plus accumulator bytes
//   ovf, udf         : sticky dropped-byte / empty-pop flags
module literal_pack_fifo
    import lz4_pkg::*;
#(
    parameter int unsigned WORD_BYTES  = WORD_BYTES_DEF,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned AW          = calc_aw(DEPTH_WORDS),
    parameter int unsigned BCW         = calc_bcw(WORD_BYTES)
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic [7:0]              din,
    input  logic                    wr_en,
    input  logic                    byte_done,
    output logic [8*WORD_BYTES-1:0] dout,
    output logic [BCW-1:0]          dout_bytes,
    output logic                    valid,
    input  logic                    rd_en,
    output logic                    full,
    output logic                    empty,
    output logic [AW:0]             word_count,
    output logic [AW+BCW:0]         byte_count,
    output logic                    ovf,
    output logic                    udf
);

    localparam int unsigned DW = 8 * WORD_BYTES;
    localparam int unsigned RW = DW + BCW;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = AW + BCW + 1;

    // Write side state
    logic [WORD_BYTES-2:0][7:0] acc_q, acc_d;
    logic [BCW-1:0]             acc_cnt_q, acc_cnt_d;
    logic                       flush_pend_q, flush_pend_d;
    logic [AW-1:0]              wr_ptr_q, wr_ptr_d;

    // Read side state
    logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              ram_cnt_q, ram_cnt_d;   // words in RAM not yet fetched
    logic                       pend_q, pend_d;         // RAM rdata holds an unconsumed word
    logic                       valid_q, valid_d;
    logic [DW-1:0]              dout_q, dout_d;
    logic [BCW-1:0]             dout_bytes_q, dout_bytes_d;

    // Counters and flags
    logic [CW-1:0]              word_count_q, word_count_d;
    logic [BW-1:0]              byte_count_q, byte_count_d;
    logic                       ovf_q, ovf_d;
    logic                       udf_q, udf_d;

    // Combinational helpers
    logic                       full_w;
    logic                       wr_blocked;
    logic                       wr_acc;
    logic                       pop;
    logic                       last_lane;
    logic [BCW-1:0]             fill_cnt;
    commit_e                    commit;
    logic                       ram_we;
    logic [DW-1:0]              commit_word;
    logic                       load;
    logic                       issue;
    logic [RW-1:0]              ram_rdata;

    assign full_w     = (word_count_q == CW'(DEPTH_WORDS));
    // A pop in the same cycle does not unblock: full is from registered counts.
    assign wr_blocked = full_w || flush_pend_q;
    assign wr_acc     = wr_en && !wr_blocked;
    assign pop        = rd_en && valid_q;
    assign last_lane  = (acc_cnt_q == BCW'(WORD_BYTES - 1));
    assign fill_cnt   = acc_cnt_q + BCW'(wr_acc);

    // Commit decision. A partial word cannot normally coexist with full
    // (every commit empties the accumulator); the deferral path is defensive.
    always_comb begin
        commit       = CommitNone;
        acc_cnt_d    = acc_cnt_q;
        flush_pend_d = flush_pend_q;
        if (flush_pend_q) begin
            if (!full_w) begin
                commit       = CommitFlush;
                acc_cnt_d    = '0;
                flush_pend_d = 1'b0;
            end
        end else if (wr_acc && last_lane) begin
            commit    = CommitFull;
            acc_cnt_d = '0;
        end else if (byte_done && (fill_cnt != '0)) begin
            if (full_w) begin
                commit       = CommitDefer;
                flush_pend_d = 1'b1;
                acc_cnt_d    = fill_cnt;
            end else begin
                commit    = CommitFlush;
                acc_cnt_d = '0;
            end
        end else begin
            acc_cnt_d = fill_cnt;
        end
    end

    assign ram_we = (commit == CommitFull) || (commit == CommitFlush);

    // Word assembly: held lanes below acc_cnt plus the same-cycle byte in lane
    // acc_cnt; lanes above stay zero.
    always_comb begin
        commit_word = '0;
        acc_d       = acc_q;
        for (int unsigned i = 0; i < WORD_BYTES - 1; i++) begin
            if (BCW'(i) < acc_cnt_q) begin
                commit_word[lane_lsb(i, WORD_BYTES) +: 8] = acc_q[i];
            end
            if (wr_acc && (BCW'(i) == acc_cnt_q)) begin
                acc_d[i] = din;
            end
        end
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            if (wr_acc && (BCW'(i) == acc_cnt_q)) begin
                commit_word[lane_lsb(i, WORD_BYTES) +: 8] = din;
            end
        end
    end

    // Read pipeline: RAM rdata is a one-word buffer ahead of the output stage.
    // A new read is only issued when that buffer is free or being drained, so
    // rdata never gets overwritten before it is loaded.
    assign load  = pend_q && (!valid_q || pop);
    assign issue = (ram_cnt_q != '0) && (!pend_q || load);

    always_comb begin
        wr_ptr_d     = wr_ptr_q + AW'(ram_we);
        rd_ptr_d     = rd_ptr_q + AW'(issue);
        ram_cnt_d    = ram_cnt_q + CW'(ram_we) - CW'(issue);
        pend_d       = issue ? 1'b1 : (load ? 1'b0 : pend_q);
        valid_d      = valid_q;
        dout_d       = dout_q;
        dout_bytes_d = dout_bytes_q;
        if (load) begin
            valid_d      = 1'b1;
            dout_d       = ram_rdata[DW-1:0];
            dout_bytes_d = ram_rdata[RW-1 -: BCW];
        end else if (pop) begin
            valid_d      = 1'b0;
            dout_d       = '0;
            dout_bytes_d = '0;
        end
        word_count_d = word_count_q + CW'(ram_we) - CW'(pop);
        byte_count_d = byte_count_q + BW'(wr_acc) - (pop ? BW'(dout_bytes_q) : BW'(0));
        ovf_d        = ovf_q || (wr_en && wr_blocked);
        udf_d        = udf_q || (rd_en && !valid_q);
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            acc_q        <= '0;
            acc_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ram_cnt_q    <= '0;
            pend_q       <= 1'b0;
            valid_q      <= 1'b0;
            dout_q       <= '0;
            dout_bytes_q <= '0;
            word_count_q <= '0;
            byte_count_q <= '0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            flush_pend_q <= flush_pend_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ram_cnt_q    <= ram_cnt_d;
            pend_q       <= pend_d;
            valid_q      <= valid_d;
            dout_q       <= dout_d;
            dout_bytes_q <= dout_bytes_d;
            word_count_q <= word_count_d;
            byte_count_q <= byte_count_d;
            ovf_q        <= ovf_d;
            udf_q        <= udf_d;
        end
    end

    literal_pack_ram #(
        .WIDTH (RW),
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata ({fill_cnt, commit_word}),
        .re    (issue),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    assign dout       = dout_q;
    assign dout_bytes = dout_bytes_q;
    assign valid      = valid_q;
    assign full       = full_w;
    assign empty      = (word_count_q == '0);
    assign word_count = word_count_q;
    assign byte_count = byte_count_q;
    assign ovf        = ovf_q;
    assign udf        = udf_q;

endmodule
